// File: rtl/rotator_engine_pkg.sv
// Shared op codes and FSM state encoding for the rotator engine.
package rotator_engine_pkg;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ROR  = 3'b001;
  localparam logic [2:0] OP_ROL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rotator_engine_step.sv
// One combinational move of up to STEP positions on the data word.
// Sign fill for op 101 exists only when ROTATOR_ENGINE_SRA_EN is defined; otherwise op 101 behaves as SRL.
module rotator_engine_step
  import rotator_engine_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int STEP  = 4,
  parameter int S_W   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       op_i,
  input  logic [S_W-1:0]   s_i,
  output logic [WIDTH-1:0] q_o,
  output logic             carry_o
);

  logic [31:0]      s_ext;
  logic [31:0]      back;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] out_hi;
  logic [WIDTH-1:0] out_lo;
  logic [WIDTH-1:0] r_tmp;
  logic             carry_l;
  logic             carry_r;

  // Shift amounts of WIDTH or more give zero, so s_i==0 degrades safely.
  always_comb begin
    s_ext   = 32'(s_i);
    back    = 32'(WIDTH) - s_ext;
    shl     = q_i << s_ext;
    shr     = q_i >> s_ext;
    out_hi  = q_i >> back;
    out_lo  = q_i << back;
    r_tmp   = q_i >> (s_ext - 32'd1);
    carry_l = out_hi[0];
    carry_r = r_tmp[0];
    q_o     = q_i;
    carry_o = 1'b0;
    case (op_i)
      OP_ROL: begin
        q_o     = shl | out_hi;
        carry_o = carry_l;
      end
      OP_SLL: begin
        q_o     = shl;
        carry_o = carry_l;
      end
      OP_ROR: begin
        q_o     = shr | out_lo;
        carry_o = carry_r;
      end
`ifdef ROTATOR_ENGINE_SRA_EN
      OP_SRL: begin
        q_o     = shr;
        carry_o = carry_r;
      end
      OP_SRA: begin
        q_o     = shr | (q_i[WIDTH-1] ? ~({WIDTH{1'b1}} >> s_ext) : '0);
        carry_o = carry_r;
      end
`else
      OP_SRL, OP_SRA: begin
        q_o     = shr;
        carry_o = carry_r;
      end
`endif
      default: begin
        q_o     = q_i;
        carry_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rotator_engine.sv
// Multi-cycle rotate/shift engine with valid/ready command intake.
// Optional arithmetic shift right enabled by ROTATOR_ENGINE_SRA_EN.
//
// state   | meaning
// IDLE    | cmd_ready high; LOAD/NOP/zero-amount commands complete here
// RUN     | moving min(remaining, STEP) bits per clock, commands ignored
module rotator_engine
  import rotator_engine_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(WIDTH) + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             carry_out,
  output logic             done
);

  localparam int S_W = $clog2(STEP + 1);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic [AMT_W-1:0] eff;
  logic [S_W-1:0]   step_s;
  logic [WIDTH-1:0] step_q;
  logic             step_c;

  always_comb begin
    eff = '0;
    case (cmd_op)
      OP_ROR, OP_ROL:         eff = cmd_amt % AMT_W'(WIDTH);
      OP_SRL, OP_SLL, OP_SRA: eff = (cmd_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : cmd_amt;
      default:                eff = '0;
    endcase
  end

  assign step_s = (rem_q > AMT_W'(STEP)) ? S_W'(STEP) : S_W'(rem_q);

  rotator_engine_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .S_W   (S_W)
  ) u_step (
    .q_i     (q_q),
    .op_i    (op_q),
    .s_i     (step_s),
    .q_o     (step_q),
    .carry_o (step_c)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    q_d     = q_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD) begin
            q_d    = load_data;
            done_d = 1'b1;
          end else if (eff != '0) begin
            state_d = ST_RUN;
            rem_d   = eff;
            op_d    = cmd_op;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        q_d     = step_q;
        carry_d = step_c;
        rem_d   = rem_q - AMT_W'(step_s);
        if (rem_d == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= OP_LOAD;
      q_q     <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign q         = q_q;
  assign carry_out = carry_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rotator_engine.sv
// Self-checking bench for rotator_engine at WIDTH=8, STEP=3 with a done-driven scoreboard.
module tb_rotator_engine;

  localparam int W     = 8;
  localparam int STEP  = 3;
  localparam int AMT_W = $clog2(W) + 2;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [W-1:0]     load_data;
  logic [W-1:0]     q;
  logic             carry_out;
  logic             done;

  rotator_engine #(.WIDTH(W), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .load_data (load_data),
    .q         (q),
    .carry_out (carry_out),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] exp_q;
    logic         exp_c;
    int           exp_edge;
  } sb_t;

  typedef struct {
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic [W-1:0]     exp_q;
    logic             exp_c;
    int               lat;
    bit               hold;
  } vec_t;

  sb_t          sb[$];
  vec_t         vecs[11];
  int           n_checks = 0;
  int           n_err    = 0;
  int           pos_cnt  = 0;
  logic [W-1:0] model_q;
  logic         model_c;

  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  // Bit-serial reference: moves one position at a time, independent of STEP.
  function automatic void ref_exec(input logic [2:0] op, input logic [AMT_W-1:0] amt,
                                   input logic [W-1:0] data, inout logic [W-1:0] mq,
                                   inout logic mc, output int lat);
    int   eff;
    logic fill;
    lat = 0;
    eff = 0;
    if (op == 3'd0) begin
      mq = data;
      return;
    end
    case (op)
      3'd1, 3'd2:       eff = int'(amt) % W;
      3'd3, 3'd4, 3'd5: eff = (int'(amt) > W) ? W : int'(amt);
      default:          eff = 0;
    endcase
    for (int i = 0; i < eff; i++) begin
      case (op)
        3'd1: begin mc = mq[0];   mq = {mq[0], mq[W-1:1]}; end
        3'd2: begin mc = mq[W-1]; mq = {mq[W-2:0], mq[W-1]}; end
        3'd3: begin mc = mq[0];   mq = {1'b0, mq[W-1:1]}; end
        3'd4: begin mc = mq[W-1]; mq = {mq[W-2:0], 1'b0}; end
        default: begin
`ifdef ROTATOR_ENGINE_SRA_EN
          fill = mq[W-1];
`else
          fill = 1'b0;
`endif
          mc = mq[0];
          mq = {fill, mq[W-1:1]};
        end
      endcase
    end
    lat = (eff + STEP - 1) / STEP;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("q_at_done", 32'(q), 32'(e.exp_q));
        check("carry_at_done", 32'(carry_out), 32'(e.exp_c));
        check("done_edge", 32'(pos_cnt), 32'(e.exp_edge));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [AMT_W-1:0] amt, input logic [W-1:0] data,
                       input logic [W-1:0] exp_q, input logic exp_c, input int lat, input bit hold);
    int   guard;
    sb_t  e;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    load_data = data;
    e.exp_q    = exp_q;
    e.exp_c    = exp_c;
    e.exp_edge = pos_cnt + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    if (hold && lat > 0) begin
      cmd_op    = 3'd0;
      load_data = 8'hFF;
      guard = 0;
      while (!cmd_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [2:0]       r_op;
    logic [AMT_W-1:0] r_amt;
    logic [W-1:0]     r_data;
    int               r_lat;

    vecs[0]  = '{3'd0, 5'd0,  8'h96, 1'b0, 0, 1'b0};
    vecs[1]  = '{3'd1, 5'd1,  8'h4B, 1'b0, 1, 1'b1};
    vecs[2]  = '{3'd2, 5'd5,  8'hD2, 1'b0, 2, 1'b1};
    vecs[3]  = '{3'd2, 5'd11, 8'hB4, 1'b0, 1, 1'b0};
    vecs[4]  = '{3'd3, 5'd20, 8'h00, 1'b1, 3, 1'b0};
`ifdef ROTATOR_ENGINE_SRA_EN
    vecs[5]  = '{3'd5, 5'd2,  8'hE5, 1'b1, 1, 1'b0};
`else
    vecs[5]  = '{3'd5, 5'd2,  8'h25, 1'b1, 1, 1'b0};
`endif
    vecs[6]  = '{3'd6, 5'd5,  8'h96, 1'b1, 0, 1'b0};
    vecs[7]  = '{3'd2, 5'd8,  8'h96, 1'b1, 0, 1'b0};
    vecs[8]  = '{3'd1, 5'd3,  8'hD2, 1'b1, 1, 1'b0};
    vecs[9]  = '{3'd4, 5'd3,  8'hB0, 1'b0, 1, 1'b0};
    vecs[10] = '{3'd1, 5'd31, 8'h2D, 1'b0, 3, 1'b0};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_amt   = '0;
    load_data = '0;
    repeat (3) @(negedge clk);
    check("reset_q", 32'(q), 32'd0);
    check("reset_carry", 32'(carry_out), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    model_q = '0;
    model_c = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      issue(3'd0, '0, 8'h96, 8'h96, model_c, 0, 1'b0);
      check("ready_after_load", 32'(cmd_ready), 32'd1);
      issue(vecs[i].op, vecs[i].amt, 8'h96, vecs[i].exp_q, vecs[i].exp_c, vecs[i].lat, vecs[i].hold);
      model_q = vecs[i].exp_q;
      model_c = vecs[i].exp_c;
    end
    drain();

    for (int i = 0; i < 16; i++) begin
      r_op   = 3'($urandom_range(0, 7));
      r_amt  = AMT_W'($urandom_range(0, 31));
      r_data = W'($urandom);
      ref_exec(r_op, r_amt, r_data, model_q, model_c, r_lat);
      issue(r_op, r_amt, r_data, model_q, model_c, r_lat, 1'b0);
    end
    drain();

    // Reset in the middle of a multi-step ROL: no done, state cleared at once.
    issue(3'd0, '0, 8'h96, 8'h96, model_c, 0, 1'b0);
    drain();
    cmd_valid = 1'b1;
    cmd_op    = 3'd2;
    cmd_amt   = 5'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("first_step_q", 32'(q), 32'hB4);
    rst_n = 1'b0;
    #1;
    check("abort_q", 32'(q), 32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check("abort_hold_done", 32'(done), 32'd0);
    check("abort_hold_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_abort_q", 32'(q), 32'd0);
    model_q = '0;
    model_c = 1'b0;
    issue(3'd0, '0, 8'h3C, 8'h3C, 1'b0, 0, 1'b0);
    drain();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
